// File: rtl/hs_cmd_slave_sclk_if.sv
// Command handshake bundle between the PCLK-side master and the SCLK-side slave.
// Request, command bus and abort come from PCLK; ack and results go back from SCLK.
interface hs_cmd_slave_sclk_if #(
  parameter int unsigned CMD_W  = 3,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 10
);
  logic              req_pclk;
  logic [CMD_W-1:0]  CMD_REG_pclk;
  logic [ADDR_W-1:0] ADDR_REG_pclk;
  logic [DATA_W-1:0] WDATA_REG_pclk;
  logic              ABORT_REG_pclk;
  logic              ack_sclk;
  logic [DATA_W-1:0] RDATA_sclk;
  logic              RESP_sclk;
  logic              busy_sclk;

  modport master (
    output req_pclk, CMD_REG_pclk, ADDR_REG_pclk, WDATA_REG_pclk, ABORT_REG_pclk,
    input  ack_sclk, RDATA_sclk, RESP_sclk, busy_sclk
  );

  modport slave (
    input  req_pclk, CMD_REG_pclk, ADDR_REG_pclk, WDATA_REG_pclk, ABORT_REG_pclk,
    output ack_sclk, RDATA_sclk, RESP_sclk, busy_sclk
  );
endinterface

// File: rtl/hs_cmd_slave_sclk.sv
// SCLK-side endpoint of the 4-phase req/ack command handshake. Executes commands
// against a small flash-like array (erased = all ones) with abort and error response.
module hs_cmd_slave_sclk #(
  parameter int unsigned CMD_W       = 3,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ROW_LEN     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BUSY_CYCLES = 3
) (
  input logic                 SCLK,
  input logic                 RESETn_sclk,
  hs_cmd_slave_sclk_if.slave  bus
);

  localparam int unsigned MaxCnt =
      (BUSY_CYCLES > ROW_LEN) ? ((BUSY_CYCLES > DEPTH) ? BUSY_CYCLES : DEPTH)
                              : ((ROW_LEN > DEPTH) ? ROW_LEN : DEPTH);
  localparam int unsigned CntW = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CMD_W-1:0] CmdRead      = CMD_W'(1);
  localparam logic [CMD_W-1:0] CmdWrite     = CMD_W'(2);
  localparam logic [CMD_W-1:0] CmdRowWrite  = CMD_W'(3);
  localparam logic [CMD_W-1:0] CmdErase     = CMD_W'(4);
  localparam logic [CMD_W-1:0] CmdMassErase = CMD_W'(5);

  typedef enum logic [1:0] {StIdle, StExec, StAck} state_e;

  logic [SYNC_STAGES-1:0] req_sync_q, abort_sync_q;
  logic                   req_d_q;
  logic                   req_s, req_rise, abort_s;

  state_e            state_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [IdxW-1:0]   addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CntW-1:0]   cnt_q;
  logic              ack_q, resp_q, busy_q;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IdxW-1:0]   mem_idx, row_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic              op_done, cmd_legal, addr_ok;

  assign req_s    = req_sync_q[SYNC_STAGES-1];
  assign abort_s  = abort_sync_q[SYNC_STAGES-1];
  assign req_rise = req_s & ~req_d_q;

  assign cmd_legal = (bus.CMD_REG_pclk >= CmdRead) && (bus.CMD_REG_pclk <= CmdMassErase);
  assign addr_ok   = 32'(bus.ADDR_REG_pclk) < 32'(DEPTH);

  assign bus.ack_sclk   = ack_q;
  assign bus.RDATA_sclk = rdata_q;
  assign bus.RESP_sclk  = resp_q;
  assign bus.busy_sclk  = busy_q;

  // Synchronise req and abort into SCLK; req_d_q gives the rising-edge detector.
  always_ff @(posedge SCLK or negedge RESETn_sclk) begin
    if (!RESETn_sclk) begin
      req_sync_q   <= '0;
      abort_sync_q <= '0;
      req_d_q      <= 1'b0;
    end else begin
      req_sync_q   <= {req_sync_q[SYNC_STAGES-2:0], bus.req_pclk};
      abort_sync_q <= {abort_sync_q[SYNC_STAGES-2:0], bus.ABORT_REG_pclk};
      req_d_q      <= req_s;
    end
  end

  // Decode the array write and completion for the current EXEC cycle; abort suppresses both.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = addr_q;
    mem_wdata = wdata_q;
    op_done   = 1'b0;
    row_idx   = (addr_q & ~IdxW'(ROW_LEN - 1)) + cnt_q[IdxW-1:0];
    if (state_q == StExec && !abort_s) begin
      unique case (cmd_q)
        CmdRead: op_done = (cnt_q == CntW'(BUSY_CYCLES - 1));
        CmdWrite: begin
          op_done = (cnt_q == CntW'(BUSY_CYCLES - 1));
          mem_we  = op_done;
        end
        CmdErase: begin
          op_done   = (cnt_q == CntW'(BUSY_CYCLES - 1));
          mem_we    = op_done;
          mem_wdata = '1;
        end
        CmdRowWrite: begin
          mem_we  = 1'b1;
          mem_idx = row_idx;
          op_done = (cnt_q == CntW'(ROW_LEN - 1));
        end
        CmdMassErase: begin
          mem_we    = 1'b1;
          mem_idx   = cnt_q[IdxW-1:0];
          mem_wdata = '1;
          op_done   = (cnt_q == CntW'(DEPTH - 1));
        end
        default: ;
      endcase
    end
  end

  // Command FSM: capture on req rise, run EXEC, hold ACK until req_s falls.
  always_ff @(posedge SCLK or negedge RESETn_sclk) begin
    if (!RESETn_sclk) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_rise) begin
            cmd_q   <= bus.CMD_REG_pclk;
            addr_q  <= bus.ADDR_REG_pclk[IdxW-1:0];
            wdata_q <= bus.WDATA_REG_pclk;
            cnt_q   <= '0;
            if (cmd_legal && addr_ok) begin
              state_q <= StExec;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StAck;
              ack_q   <= 1'b1;
              resp_q  <= 1'b1;
            end
          end
        end
        StExec: begin
          if (abort_s) begin
            state_q <= StAck;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            resp_q  <= 1'b1;
          end else if (op_done) begin
            state_q <= StAck;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            resp_q  <= 1'b0;
            if (cmd_q == CmdRead) rdata_q <= mem_q[addr_q];
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StAck: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array storage; reset returns every word to the erased state.
  always_ff @(posedge SCLK or negedge RESETn_sclk) begin
    if (!RESETn_sclk) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '1;
    end else if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_hs_cmd_slave_sclk.sv
// Self-checking bench for hs_cmd_slave_sclk: table vectors, corner sequences and
// randomized commands against an edge-count/array reference model.
module tb_hs_cmd_slave_sclk;
  localparam int unsigned CMD_W       = 3;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned DATA_W      = 10;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned ROW_LEN     = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned BUSY_CYCLES = 3;
  localparam int          Ones        = (1 << DATA_W) - 1;
  localparam int          Sync        = int'(SYNC_STAGES);

  logic SCLK = 1'b0;
  logic RESETn_sclk = 1'b0;

  hs_cmd_slave_sclk_if #(.CMD_W(CMD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  hs_cmd_slave_sclk #(
    .CMD_W(CMD_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .ROW_LEN(ROW_LEN), .SYNC_STAGES(SYNC_STAGES), .BUSY_CYCLES(BUSY_CYCLES)
  ) dut (
    .SCLK(SCLK),
    .RESETn_sclk(RESETn_sclk),
    .bus(bus)
  );

  always #5 SCLK = ~SCLK;

  int n_cmp = 0;
  int n_fail = 0;
  int model_mem[DEPTH];
  int model_rdata;

  typedef struct {
    int cmd;
    int addr;
    int wdata;
    int abort_at;
    int exp_rdata;
    int exp_resp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int cmd, int addr, int wdata, int abort_at, int exp_rdata,
                              int exp_resp);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.abort_at = abort_at;
    v.exp_rdata = exp_rdata; v.exp_resp = exp_resp;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = Ones;
    model_rdata = 0;
  endtask

  // One full 4-phase transaction. abort_at: -1 none, 0 with req, n after n SCLK edges.
  // The model predicts ack timing in SCLK edges after req and the array effect.
  task automatic do_cmd(input int cmd, input int addr, input int wdata, input int abort_at,
                        input int hold, output int act_rdata, output int act_resp,
                        output int exp_rdata, output int exp_resp);
    int first, len, n_edge, e_edge, exp_edge, nw, edges, busy_seen, base;
    bit legal, aborted, seen;
    first   = Sync + 2;
    legal   = (cmd >= 1 && cmd <= 5) && (addr < int'(DEPTH));
    aborted = 0;
    nw      = 0;
    if (!legal) begin
      exp_edge = Sync + 1;
      exp_resp = 1;
    end else begin
      len    = (cmd == 3) ? int'(ROW_LEN) : (cmd == 5) ? int'(DEPTH) : int'(BUSY_CYCLES);
      n_edge = Sync + 1 + len;
      e_edge = (abort_at >= 0) ? abort_at + Sync + 1 : n_edge + 1;
      if (e_edge <= n_edge) begin
        aborted  = 1;
        exp_edge = (e_edge > first) ? e_edge : first;
        nw       = exp_edge - first;
      end else begin
        exp_edge = n_edge;
        nw       = len;
      end
      exp_resp = int'(aborted);
      base     = addr - (addr % int'(ROW_LEN));
      case (cmd)
        1: if (!aborted) model_rdata = model_mem[addr];
        2: if (!aborted) model_mem[addr] = wdata;
        3: for (int i = 0; i < nw; i++) model_mem[base + i] = wdata;
        4: if (!aborted) model_mem[addr] = Ones;
        5: for (int i = 0; i < nw; i++) model_mem[i] = Ones;
        default: ;
      endcase
    end
    exp_rdata = model_rdata;

    @(negedge SCLK);
    bus.CMD_REG_pclk   = CMD_W'(cmd);
    bus.ADDR_REG_pclk  = ADDR_W'(addr);
    bus.WDATA_REG_pclk = DATA_W'(wdata);
    bus.ABORT_REG_pclk = (abort_at == 0);
    bus.req_pclk       = 1'b1;
    edges = 0; busy_seen = 0; seen = 0;
    while (!seen && edges < 100) begin
      @(negedge SCLK);
      edges++;
      if (abort_at > 0 && edges == abort_at) bus.ABORT_REG_pclk = 1'b1;
      if (bus.busy_sclk) busy_seen++;
      if (bus.ack_sclk) seen = 1;
    end
    if (!seen) check("ack_timeout", 0, 1);
    check("ack_latency", edges, exp_edge);
    check("busy_cycles", busy_seen, legal ? exp_edge - (Sync + 1) : 0);
    act_rdata = int'(bus.RDATA_sclk);
    act_resp  = int'(bus.RESP_sclk);

    // Bus churn while waiting in ACK must not be picked up.
    for (int i = 0; i < hold; i++) begin
      @(negedge SCLK);
      bus.CMD_REG_pclk   = CMD_W'($urandom);
      bus.ADDR_REG_pclk  = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.WDATA_REG_pclk = DATA_W'($urandom);
    end
    if (hold > 0) begin
      check("ack_held", int'(bus.ack_sclk), 1);
      check("rdata_held", int'(bus.RDATA_sclk), exp_rdata);
    end

    bus.req_pclk       = 1'b0;
    bus.ABORT_REG_pclk = 1'b0;
    edges = 0;
    do begin
      @(negedge SCLK);
      edges++;
    end while (bus.ack_sclk && edges < 50);
    check("ack_fall", edges, Sync + 1);
    @(negedge SCLK);
    check("resp_after_ack", int'(bus.RESP_sclk), exp_resp);
  endtask

  int ar, ap, er, ep;

  initial begin
    bus.req_pclk       = 1'b0;
    bus.CMD_REG_pclk   = '0;
    bus.ADDR_REG_pclk  = '0;
    bus.WDATA_REG_pclk = '0;
    bus.ABORT_REG_pclk = 1'b0;
    model_reset();

    repeat (3) @(negedge SCLK);
    check("rst_ack", int'(bus.ack_sclk), 0);
    check("rst_busy", int'(bus.busy_sclk), 0);
    check("rst_rdata", int'(bus.RDATA_sclk), 0);
    check("rst_resp", int'(bus.RESP_sclk), 0);
    RESETn_sclk = 1'b1;
    repeat (2) @(negedge SCLK);

    vecs.push_back(mk(2, 5, 'h2A5, -1, 'h000, 0));
    vecs.push_back(mk(1, 5, 0, -1, 'h2A5, 0));
    vecs.push_back(mk(3, 6, 'h155, -1, 'h2A5, 0));
    vecs.push_back(mk(1, 3, 0, -1, 'h3FF, 0));
    vecs.push_back(mk(1, 4, 0, -1, 'h155, 0));
    vecs.push_back(mk(1, 5, 0, -1, 'h155, 0));
    vecs.push_back(mk(1, 6, 0, -1, 'h155, 0));
    vecs.push_back(mk(1, 7, 0, -1, 'h155, 0));
    vecs.push_back(mk(1, 8, 0, -1, 'h3FF, 0));
    vecs.push_back(mk(7, 1, 0, -1, 'h3FF, 1));
    vecs.push_back(mk(1, 20, 0, -1, 'h3FF, 1));
    vecs.push_back(mk(0, 2, 0, -1, 'h3FF, 1));
    vecs.push_back(mk(2, 20, 'h000, -1, 'h3FF, 1));
    vecs.push_back(mk(1, 4, 0, -1, 'h155, 0));
    vecs.push_back(mk(4, 4, 0, -1, 'h155, 0));
    vecs.push_back(mk(1, 4, 0, -1, 'h3FF, 0));
    vecs.push_back(mk(2, 9, 'h000, 0, 'h3FF, 1));
    vecs.push_back(mk(1, 9, 0, -1, 'h3FF, 0));

    foreach (vecs[i]) begin
      do_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, vecs[i].abort_at, 0, ar, ap, er, ep);
      check($sformatf("vec%0d_rdata", i), ar, vecs[i].exp_rdata);
      check($sformatf("vec%0d_resp", i), ap, vecs[i].exp_resp);
    end

    // Request held high long after ack while the bus churns: one WRITE only.
    do_cmd(2, 9, 'h0F0, -1, 50, ar, ap, er, ep);
    check("hold_resp", ap, 0);
    do_cmd(1, 9, 0, -1, 0, ar, ap, er, ep);
    check("hold_read9", ar, 'h0F0);
    for (int a = 0; a < int'(DEPTH); a++) begin
      do_cmd(1, a, 0, -1, 0, ar, ap, er, ep);
      check($sformatf("hold_scan%0d", a), ar, er);
    end

    // Mass erase aborted when the counter sits at 7.
    for (int a = 0; a < int'(DEPTH); a++) do_cmd(2, a, 'h000, -1, 0, ar, ap, er, ep);
    do_cmd(5, 0, 0, 8, 0, ar, ap, er, ep);
    check("mass_abort_resp", ap, 1);
    for (int a = 0; a < int'(DEPTH); a++) begin
      do_cmd(1, a, 0, -1, 0, ar, ap, er, ep);
      check($sformatf("mass_word%0d", a), ar, (a < 7) ? 'h3FF : 'h000);
    end

    // Randomized commands, including aborts and out-of-range addresses.
    for (int n = 0; n < 40; n++) begin
      int c, a, w, ab, h;
      c  = $urandom_range(0, 7);
      a  = $urandom_range(0, 19);
      w  = $urandom_range(0, Ones);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
      h  = $urandom_range(0, 3);
      do_cmd(c, a, w, ab, h, ar, ap, er, ep);
      check($sformatf("rnd%0d_c%0d_rdata", n, c), ar, er);
      check($sformatf("rnd%0d_c%0d_resp", n, c), ap, ep);
    end

    // Reset during EXEC of a WRITE: no ack, array erased, outputs cleared.
    do_cmd(2, 2, 'h055, -1, 0, ar, ap, er, ep);
    do_cmd(1, 2, 0, -1, 0, ar, ap, er, ep);
    check("pre_reset_read2", ar, 'h055);
    @(negedge SCLK);
    bus.CMD_REG_pclk   = CMD_W'(2);
    bus.ADDR_REG_pclk  = ADDR_W'(2);
    bus.WDATA_REG_pclk = DATA_W'('h0AA);
    bus.req_pclk       = 1'b1;
    repeat (4) @(negedge SCLK);
    check("busy_before_reset", int'(bus.busy_sclk), 1);
    #2 RESETn_sclk = 1'b0;
    #1;
    check("reset_ack", int'(bus.ack_sclk), 0);
    check("reset_busy", int'(bus.busy_sclk), 0);
    check("reset_rdata", int'(bus.RDATA_sclk), 0);
    bus.req_pclk = 1'b0;
    model_reset();
    @(negedge SCLK);
    RESETn_sclk = 1'b1;
    repeat (2) @(negedge SCLK);
    do_cmd(1, 2, 0, -1, 0, ar, ap, er, ep);
    check("post_reset_read2", ar, 'h3FF);
    check("post_reset_resp", ap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
